// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between the display
// fetch (absolute priority, no handshake) and the CPU bus (req/ack handshake).
// A CPU access takes one grant cycle and then one ACK cycle. The ACK cycle
// blocks a second issue while the requester still sees cpu_ack.
module vram_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_rdata,
  output logic                  disp_valid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_starved,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic [15:0] STARVE_LIM_C = 16'(STARVE_LIMIT);
  localparam logic [15:0] CNT_MAX_C    = 16'hFFFF;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    disp_grant_s;
  logic                    cpu_grant_s;
  logic [15:0]             wait_cnt_r;
  logic [15:0]             wait_cnt_nxt_s;
  logic                    cpu_rd_ack_r;
  logic [DATA_WIDTH-1:0]   cpu_rdata_r;

  // Grant decode: display first, CPU only from IDLE, nothing while in reset
  always_comb begin
    disp_grant_s = 1'b0;
    cpu_grant_s  = 1'b0;
    if (rst) begin
      disp_grant_s = 1'b0;
    end else if (disp_req) begin
      disp_grant_s = 1'b1;
    end else if (cpu_req && (state_r == IDLE)) begin
      cpu_grant_s = 1'b1;
    end else begin
      cpu_grant_s = 1'b0;
    end
  end

  // VRAM port mux driven straight from the grant
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_WIDTH{1'b0}};
    mem_wdata = {DATA_WIDTH{1'b0}};
    if (disp_grant_s) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (cpu_grant_s) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else begin
      mem_en = 1'b0;
    end
  end

  // Next-state logic: one ACK cycle after every CPU grant
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cpu_grant_s) begin
          state_nxt_s = ACK;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Starvation counter: counts cycles the display blocks a pending CPU request
  always_comb begin
    wait_cnt_nxt_s = wait_cnt_r;
    if (cpu_grant_s || !cpu_req) begin
      wait_cnt_nxt_s = 16'd0;
    end else if ((state_r == IDLE) && disp_req) begin
      if (wait_cnt_r != CNT_MAX_C) begin
        wait_cnt_nxt_s = wait_cnt_r + 16'd1;
      end else begin
        wait_cnt_nxt_s = wait_cnt_r;
      end
    end else begin
      wait_cnt_nxt_s = wait_cnt_r;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered handshake, valid, starvation flag and CPU read-data hold
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_valid   <= 1'b0;
      cpu_ack      <= 1'b0;
      cpu_rd_ack_r <= 1'b0;
      cpu_rdata_r  <= {DATA_WIDTH{1'b0}};
      cpu_starved  <= 1'b0;
      wait_cnt_r   <= 16'd0;
    end else begin
      disp_valid   <= disp_grant_s;
      cpu_ack      <= cpu_grant_s;
      cpu_rd_ack_r <= cpu_grant_s && !cpu_we;
      wait_cnt_r   <= wait_cnt_nxt_s;
      if (cpu_rd_ack_r) begin
        cpu_rdata_r <= mem_rdata;
      end else begin
        cpu_rdata_r <= cpu_rdata_r;
      end
      if (cpu_grant_s) begin
        cpu_starved <= 1'b0;
      end else if (wait_cnt_nxt_s >= STARVE_LIM_C) begin
        cpu_starved <= 1'b1;
      end else begin
        cpu_starved <= cpu_starved;
      end
    end
  end

  // Read data: RAM output passes through in the valid/ack cycle, CPU copy holds afterwards
  assign disp_rdata = disp_valid ? mem_rdata : {DATA_WIDTH{1'b0}};
  assign cpu_rdata  = cpu_rd_ack_r ? mem_rdata : cpu_rdata_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small synchronous RAM model.
module tb_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        disp_req;
  logic [11:0] disp_addr;
  logic [7:0]  disp_rdata;
  logic        disp_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_starved;
  logic        mem_en;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [4096];

  int n_checks = 0;
  int n_errors = 0;

  vram_arbiter #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(8),
    .STARVE_LIMIT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .disp_req(disp_req),
    .disp_addr(disp_addr),
    .disp_rdata(disp_rdata),
    .disp_valid(disp_valid),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .cpu_starved(cpu_starved),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 1-cycle read latency, read-before-write
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem_rdata = 8'h00;

    // 1. reset with both requests high
    rst = 1'b1; disp_req = 1'b1; disp_addr = 12'h020;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010; cpu_wdata = 8'h00;
    tick;
    #1 check_val("rst_mem_en", 16'(mem_en), 16'd0);
    tick;
    check_val("rst_disp_valid", 16'(disp_valid), 16'd0);
    check_val("rst_cpu_ack", 16'(cpu_ack), 16'd0);
    check_val("rst_starved", 16'(cpu_starved), 16'd0);
    check_val("rst_cpu_rdata", 16'(cpu_rdata), 16'h00);
    check_val("rst_mem_en2", 16'(mem_en), 16'd0);
    rst = 1'b0;
    #1 check_val("post_rst_disp_en", 16'(mem_en), 16'd1);
    check_val("post_rst_disp_addr", 16'(mem_addr), 16'h020);
    check_val("post_rst_disp_we", 16'(mem_we), 16'd0);
    tick;
    check_val("post_rst_disp_valid", 16'(disp_valid), 16'd1);
    check_val("post_rst_disp_rdata", 16'(disp_rdata), 16'h7A);
    check_val("post_rst_no_ack", 16'(cpu_ack), 16'd0);
    disp_req = 1'b0; cpu_req = 1'b0;
    #1 check_val("idle_mem_en", 16'(mem_en), 16'd0);
    tick;
    check_val("idle_disp_valid", 16'(disp_valid), 16'd0);

    // 2. CPU write then read back
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_wdata = 8'hA5;
    #1 check_val("wr_mem_en", 16'(mem_en), 16'd1);
    check_val("wr_mem_we", 16'(mem_we), 16'd1);
    check_val("wr_mem_addr", 16'(mem_addr), 16'h123);
    check_val("wr_mem_wdata", 16'(mem_wdata), 16'hA5);
    tick;
    check_val("wr_ack", 16'(cpu_ack), 16'd1);
    cpu_req = 1'b0;
    #1 check_val("wr_ack_cycle_en", 16'(mem_en), 16'd0);
    tick;
    check_val("wr_ack_pulse", 16'(cpu_ack), 16'd0);
    cpu_req = 1'b1; cpu_we = 1'b0;
    #1 check_val("rd_mem_en", 16'(mem_en), 16'd1);
    check_val("rd_mem_we", 16'(mem_we), 16'd0);
    tick;
    check_val("rd_ack", 16'(cpu_ack), 16'd1);
    check_val("rd_data", 16'(cpu_rdata), 16'hA5);
    cpu_req = 1'b0;
    tick;
    check_val("rd_ack_pulse", 16'(cpu_ack), 16'd0);
    check_val("rd_data_hold", 16'(cpu_rdata), 16'hA5);

    // 4. request held high: one access every two cycles
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h200; cpu_wdata = 8'h3C;
    for (int j = 0; j < 4; j++) begin
      #1 check_val($sformatf("hold_en_%0d", j), 16'(mem_en), (j % 2 == 0) ? 16'd1 : 16'd0);
      tick;
      check_val($sformatf("hold_ack_%0d", j), 16'(cpu_ack), (j % 2 == 0) ? 16'd1 : 16'd0);
    end
    cpu_req = 1'b0;
    check_val("wr_keeps_rdata", 16'(cpu_rdata), 16'hA5);

    // 3. display pattern 1,1,1,0 with a CPU read pending
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0AB;
    for (int i = 0; i < 8; i++) begin
      disp_req  = (i % 4 != 3);
      disp_addr = 12'h040 + 12'(i);
      #1;
      check_val($sformatf("pat_en_%0d", i), 16'(mem_en), (i != 7) ? 16'd1 : 16'd0);
      check_val($sformatf("pat_we_%0d", i), 16'(mem_we), 16'd0);
      if (i != 7)
        check_val($sformatf("pat_addr_%0d", i), 16'(mem_addr),
                  (i == 3) ? 16'h0AB : 16'(12'h040 + 12'(i)));
      tick;
      check_val($sformatf("pat_valid_%0d", i), 16'(disp_valid), (i % 4 != 3) ? 16'd1 : 16'd0);
      if (i % 4 != 3)
        check_val($sformatf("pat_rdata_%0d", i), 16'(disp_rdata), 16'((8'h40 + 8'(i)) ^ 8'h5A));
      check_val($sformatf("pat_ack_%0d", i), 16'(cpu_ack), (i == 3) ? 16'd1 : 16'd0);
      if (i == 3) begin
        check_val("pat_cpu_rdata", 16'(cpu_rdata), 16'hF1);
        cpu_req = 1'b0;
      end
    end

    // 5. starvation under continuous display traffic
    disp_req = 1'b1; disp_addr = 12'h300;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0CD;
    for (int k = 1; k <= 70; k++) begin
      tick;
      if (k == 63) check_val("starve_63", 16'(cpu_starved), 16'd0);
      if (k == 64) check_val("starve_64", 16'(cpu_starved), 16'd1);
      if (k == 70) begin
        check_val("starve_70", 16'(cpu_starved), 16'd1);
        check_val("starve_no_ack", 16'(cpu_ack), 16'd0);
      end
    end
    disp_req = 1'b0;
    #1 check_val("starve_grant_en", 16'(mem_en), 16'd1);
    check_val("starve_grant_addr", 16'(mem_addr), 16'h0CD);
    tick;
    check_val("starve_ack", 16'(cpu_ack), 16'd1);
    check_val("starve_clear", 16'(cpu_starved), 16'd0);
    check_val("starve_rdata", 16'(cpu_rdata), 16'h97);
    cpu_req = 1'b0;
    tick;

    // 6. reset in a CPU grant cycle
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h055;
    #1 check_val("rst6_mem_en", 16'(mem_en), 16'd0);
    tick;
    check_val("rst6_no_ack", 16'(cpu_ack), 16'd0);
    check_val("rst6_rdata", 16'(cpu_rdata), 16'h00);
    rst = 1'b0; cpu_req = 1'b0;
    tick;
    check_val("rst6_no_ack2", 16'(cpu_ack), 16'd0);
    cpu_req = 1'b1;
    #1 check_val("rst6_idle_grant", 16'(mem_en), 16'd1);
    check_val("rst6_idle_addr", 16'(mem_addr), 16'h055);
    tick;
    check_val("rst6_ack", 16'(cpu_ack), 16'd1);
    check_val("rst6_rdata_new", 16'(cpu_rdata), 16'h0F);
    cpu_req = 1'b0;
    tick;

    // withdrawn request is never acknowledged
    disp_req = 1'b1; disp_addr = 12'h001; cpu_req = 1'b1; cpu_addr = 12'h066;
    tick;
    disp_req = 1'b0; cpu_req = 1'b0;
    #1 check_val("withdraw_en", 16'(mem_en), 16'd0);
    tick;
    check_val("withdraw_no_ack", 16'(cpu_ack), 16'd0);
    check_val("withdraw_rdata", 16'(cpu_rdata), 16'h0F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
